ram_block_responder: RTL and testbench

//  RAM-side responder for the cache's prop_* request port. Accepts one word-write or

---
 rtl/ram_block_responder.sv | 151 +++++++++++++++
 tb/tb_ram_block_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_responder.sv
// ram_block_responder
// RAM-side responder for the cache's prop_* request port. One word-write or
// block-read is accepted at a time. After a fixed access latency, the whole
// aligned block is returned on ram_data together with a one-cycle ram_valid pulse.
// The backing word array is preloaded with word[i] = i and is not cleared by reset.
module ram_block_responder #(
  parameter int RAM_ADDRESS_BITS = 10,
  parameter int DATA_BITS        = 32,
  parameter int BLOCK_BITS       = 2,
  parameter int LATENCY          = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [RAM_ADDRESS_BITS-1:0] address,
  input  logic                        read_en,
  input  logic [DATA_BITS-1:0]        write_data,
  input  logic                        write_en,
  output logic                        ram_valid,
  output logic [DATA_BITS-1:0]        ram_data [(2**BLOCK_BITS)-1:0],
  output logic                        busy
);

  localparam int BLOCK_SIZE = 2 ** BLOCK_BITS;
  localparam int WORDS      = 2 ** RAM_ADDRESS_BITS;
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t                      state;
  state_t                      next_state;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            next_cnt;
  logic                        accept;
  logic                        enter_resp;

  logic [RAM_ADDRESS_BITS-1:0] cap_addr;
  logic [DATA_BITS-1:0]        cap_data;
  logic                        cap_write;

  logic [RAM_ADDRESS_BITS-1:0] op_addr;
  logic [DATA_BITS-1:0]        op_data;
  logic                        op_write;

  logic [RAM_ADDRESS_BITS-1:0] word_idx;
  logic [DATA_BITS-1:0]        block_next [BLOCK_SIZE-1:0];

  logic [DATA_BITS-1:0]        mem [WORDS];

  // Preload the backing array so every word initially holds its own address
  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = DATA_BITS'(i);
    end
  end

  // State, latency counter and captured request registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_write <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (accept) begin
        cap_addr  <= address;
        cap_data  <= write_data;
        cap_write <= write_en;
      end
    end
  end

  // Next-state logic; a request is taken only from IDLE and writes win over reads
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (read_en || write_en) begin
          accept     = 1'b1;
          next_cnt   = CNT_W'(LATENCY - 1);
          next_state = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        next_cnt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With a one-cycle latency the response is built on the capture edge itself,
  // so the live inputs stand in for the not-yet-loaded capture registers
  always_comb begin
    enter_resp = reset_n && (next_state == RESP);
    if (state == IDLE) begin
      op_addr  = address;
      op_data  = write_data;
      op_write = write_en;
    end else begin
      op_addr  = cap_addr;
      op_data  = cap_data;
      op_write = cap_write;
    end
  end

  // Assemble the aligned block, substituting the word being written this edge
  always_comb begin
    word_idx = '0;
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      word_idx      = {op_addr[RAM_ADDRESS_BITS-1:BLOCK_BITS], BLOCK_BITS'(k)};
      block_next[k] = (op_write && (word_idx == op_addr)) ? op_data : mem[word_idx];
    end
  end

  // Commit a write on the edge that enters RESP; an aborted write never lands
  always_ff @(posedge clk) begin
    if (enter_resp && op_write) begin
      mem[op_addr] <= op_data;
    end
  end

  // Response block register, loaded on RESP entry and held until the next load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_data <= '{default: '0};
    end else if (enter_resp) begin
      ram_data <= block_next;
    end
  end

  // Status outputs follow the state register so reset clears them immediately
  always_comb begin
    ram_valid = (state == RESP);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_ram_block_responder.sv
// tb_ram_block_responder
// Drives two responders (LATENCY 4 and LATENCY 1) from the same inputs and
// checks both against a transaction-timeline reference model.
module tb_ram_block_responder;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BB    = 2;
  localparam int BS    = 4;
  localparam int WORDS = 1024;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address;
  logic          read_en;
  logic [DW-1:0] write_data;
  logic          write_en;

  logic          valid4, busy4, valid1, busy1;
  logic [DW-1:0] data4 [BS-1:0];
  logic [DW-1:0] data1 [BS-1:0];

  int n_cmp = 0;
  int n_err = 0;

  // reference model: index 0 = LATENCY 4, index 1 = LATENCY 1
  int            lat [2] = '{4, 1};
  logic [DW-1:0] mdl_mem [2][WORDS];
  int            mdl_next [2];
  int            mdl_resp [2];
  logic          mdl_wr [2];
  logic [AW-1:0] mdl_addr [2];
  logic [DW-1:0] mdl_wdata [2];
  logic [DW-1:0] exp_blk [2][BS];
  int            edge_n = 0;

  // observed pulse bookkeeping for directed checks
  int            cnt_p [2];
  int            last_p [2];
  int            prev_p [2];
  logic [DW-1:0] obs4 [BS];
  int            cap_edge;

  always #5 clk = ~clk;

  ram_block_responder #(.RAM_ADDRESS_BITS(AW), .DATA_BITS(DW), .BLOCK_BITS(BB), .LATENCY(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .address(address), .read_en(read_en),
    .write_data(write_data), .write_en(write_en),
    .ram_valid(valid4), .ram_data(data4), .busy(busy4));

  ram_block_responder #(.RAM_ADDRESS_BITS(AW), .DATA_BITS(DW), .BLOCK_BITS(BB), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .read_en(read_en),
    .write_data(write_data), .write_en(write_en),
    .ram_valid(valid1), .ram_data(data1), .busy(busy1));

  task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 2; i++) begin
      mdl_next[i] = 0;
      mdl_resp[i] = -100;
    end
  endtask

  // one rising edge as seen by the model: accept if free, complete if due
  task automatic modelEdge();
    logic [AW-1:0] base;
    for (int i = 0; i < 2; i++) begin
      if (reset_n && edge_n >= mdl_next[i] && (read_en || write_en)) begin
        mdl_resp[i]  = edge_n + lat[i] - 1;
        mdl_next[i]  = edge_n + lat[i] + 2;
        mdl_wr[i]    = write_en;
        mdl_addr[i]  = address;
        mdl_wdata[i] = write_data;
      end
      if (edge_n == mdl_resp[i]) begin
        if (mdl_wr[i]) mdl_mem[i][mdl_addr[i]] = mdl_wdata[i];
        base = mdl_addr[i] & ~AW'(BS - 1);
        for (int k = 0; k < BS; k++) exp_blk[i][k] = mdl_mem[i][int'(base) + k];
      end
    end
  endtask

  task automatic checkOutput();
    logic ev;
    ev = (edge_n == mdl_resp[0]);
    cmp("lat4_valid", DW'(valid4), DW'(ev));
    cmp("lat4_busy", DW'(busy4), DW'(edge_n < mdl_next[0] - 1));
    if (ev) for (int k = 0; k < BS; k++) cmp($sformatf("lat4_data%0d", k), data4[k], exp_blk[0][k]);
    ev = (edge_n == mdl_resp[1]);
    cmp("lat1_valid", DW'(valid1), DW'(ev));
    cmp("lat1_busy", DW'(busy1), DW'(edge_n < mdl_next[1] - 1));
    if (ev) for (int k = 0; k < BS; k++) cmp($sformatf("lat1_data%0d", k), data1[k], exp_blk[1][k]);
    if (valid4 === 1'b1) begin
      prev_p[0] = last_p[0]; last_p[0] = edge_n; cnt_p[0]++;
      for (int k = 0; k < BS; k++) obs4[k] = data4[k];
    end
    if (valid1 === 1'b1) begin
      prev_p[1] = last_p[1]; last_p[1] = edge_n; cnt_p[1]++;
    end
  endtask

  // drive one cycle of inputs, clock it, and check both responders
  task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    read_en    = rd;
    write_en   = wr;
    address    = a;
    write_data = d;
    @(posedge clk);
    edge_n++;
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic pulseReset(input string tag);
    reset_n = 1'b0;
    modelClear();
    #1;
    cmp({tag, "_valid4"}, DW'(valid4), '0);
    cmp({tag, "_busy4"}, DW'(busy4), '0);
    cmp({tag, "_valid1"}, DW'(valid1), '0);
    cmp({tag, "_busy1"}, DW'(busy1), '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    reset_n = 1'b1;
  endtask

  task automatic clearPulses();
    for (int i = 0; i < 2; i++) begin
      cnt_p[i] = 0; last_p[i] = -1; prev_p[i] = -1;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < WORDS; w++) mdl_mem[i][w] = DW'(w);
    modelClear();
    clearPulses();
    reset_n = 1'b0; read_en = 1'b0; write_en = 1'b0; address = '0; write_data = '0;
    #1;
    cmp("rst_valid4", DW'(valid4), '0);
    cmp("rst_busy4", DW'(busy4), '0);
    cmp("rst_data4_0", data4[0], '0);
    cmp("rst_valid1", DW'(valid1), '0);
    idle(2);
    reset_n = 1'b1;

    // test 1: block read of 0x005, latency check on both instances
    clearPulses();
    cap_edge = edge_n + 1;
    applyStimulus(1'b1, 1'b0, 10'h005, '0);
    idle(8);
    cmp("t1_lat4_edge", DW'(last_p[0] - cap_edge), DW'(3));
    cmp("t1_lat1_edge", DW'(last_p[1] - cap_edge), DW'(0));
    cmp("t1_pulses4", DW'(cnt_p[0]), DW'(1));
    cmp("t1_blk0", obs4[0], 32'h4);
    cmp("t1_blk3", obs4[3], 32'h7);

    // test 2: word write then read of the same block
    applyStimulus(1'b0, 1'b1, 10'h012, 32'hDEADBEEF);
    idle(8);
    cmp("t2_wr_blk2", obs4[2], 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 10'h010, '0);
    idle(8);
    cmp("t2_rd_blk1", obs4[1], 32'h11);
    cmp("t2_rd_blk2", obs4[2], 32'hDEADBEEF);

    // test 3: read and write together act as a write
    applyStimulus(1'b1, 1'b1, 10'h021, 32'h55);
    idle(8);
    applyStimulus(1'b1, 1'b0, 10'h020, '0);
    idle(8);
    cmp("t3_blk1", obs4[1], 32'h55);
    cmp("t3_blk0", obs4[0], 32'h20);

    // test 4: request held across the whole transaction
    clearPulses();
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 10'h008, '0);
    idle(8);
    cmp("t4_pulses4", DW'(cnt_p[0]), DW'(2));
    cmp("t4_gap4", DW'(last_p[0] - prev_p[0]), DW'(6));
    cmp("t4_pulses1", DW'(cnt_p[1]), DW'(4));
    cmp("t4_gap1", DW'(last_p[1] - prev_p[1]), DW'(3));

    // test 5: reset during the wait discards the pending write
    applyStimulus(1'b0, 1'b1, 10'h030, 32'hAA);
    idle(1);
    pulseReset("t5");
    applyStimulus(1'b1, 1'b0, 10'h030, '0);
    idle(8);
    cmp("t5_blk0", obs4[0], 32'h30);

    // test 6: top block, no wrap
    applyStimulus(1'b1, 1'b0, 10'h3FF, '0);
    idle(8);
    cmp("t6_blk0", obs4[0], 32'h3FC);
    cmp("t6_blk3", obs4[3], 32'h3FF);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulseReset("rnd_rst");
      end else begin
        applyStimulus(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                      AW'($urandom), DW'($urandom));
      end
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
